// File: rtl/axi_stream_header_arbiter.sv
// Round-robin arbiter sharing the inserter's single header port among NUM_REQ sources.
// Optional packet watchdog enabled by defining HDR_ARB_TIMEOUT_EN.
module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD/8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CYC  = 64
)(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]        req_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0]   req_keep,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0]    req_byte_cnt,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              valid_insert,
  output logic [DATA_WD-1:0]                data_insert,
  output logic [DATA_BYTE_WD-1:0]           keep_insert,
  output logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
  input  logic                              ready_insert,
  input  logic                              valid_out,
  input  logic                              ready_out,
  input  logic                              last_out,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
`ifdef HDR_ARB_TIMEOUT_EN
  output logic                              timeout_err,
`endif
  output logic                              busy
);
  localparam int ID_WD = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("axi_stream_header_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, HDR, PKT} state_t;

  typedef struct packed {
    logic [DATA_WD-1:0]      data;
    logic [DATA_BYTE_WD-1:0] keep;
    logic [BYTE_CNT_WD-1:0]  cnt;
  } hdr_t;

  state_t                               state, state_n;
  logic [ID_WD-1:0]                     ptr, ptr_n, sel, nxt;
  logic                                 found, grant, beat, eop;
  hdr_t                                 hdr_q;
  logic [NUM_REQ-1:0][DATA_WD-1:0]      rd;
  logic [NUM_REQ-1:0][DATA_BYTE_WD-1:0] rk;
  logic [NUM_REQ-1:0][BYTE_CNT_WD-1:0]  rc;

  assign rd = req_data;
  assign rk = req_keep;
  assign rc = req_byte_cnt;

  assign beat = valid_out && ready_out;
  assign eop  = beat && last_out;
  assign nxt  = (grant_id == ID_WD'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[ID_WD'((int'(ptr) + k) % NUM_REQ)]) begin
        found = 1'b1;
        sel   = ID_WD'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

`ifdef HDR_ARB_TIMEOUT_EN
  localparam int TC_WD = $clog2(TIMEOUT_CYC) + 1;
  logic [TC_WD-1:0] tcnt;
  logic             tmo;
  assign tmo = (state == PKT) && !beat && (tcnt == TC_WD'(TIMEOUT_CYC-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo;
      if (state != PKT || beat) tcnt <= '0;
      else                      tcnt <= tcnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    grant        = 1'b0;
    req_ready    = '0;
    valid_insert = 1'b0;
    case (state)
      IDLE: if (found) begin
        // Gated by reset so an abandoned cycle never consumes a header.
        req_ready[sel] = rst_n;
        grant          = 1'b1;
        state_n        = HDR;
      end
      HDR: begin
        valid_insert = 1'b1;
        if (ready_insert) state_n = PKT;
      end
      PKT: begin
        if (eop) begin
          state_n = IDLE;
          ptr_n   = nxt;
        end
`ifdef HDR_ARB_TIMEOUT_EN
        else if (tmo) begin
          state_n = IDLE;
          ptr_n   = nxt;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      hdr_q    <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      if (grant) begin
        grant_id <= sel;
        hdr_q    <= '{data: rd[sel], keep: rk[sel], cnt: rc[sel]};
      end
    end
  end

  assign data_insert     = hdr_q.data;
  assign keep_insert     = hdr_q.keep;
  assign byte_insert_cnt = hdr_q.cnt;
  assign busy            = (state != IDLE);
endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Directed bench for axi_stream_header_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_axi_stream_header_arbiter;
  localparam int DW = 32, BW = 4, CW = 2, N = 4, IW = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data;
  logic [N*BW-1:0] req_keep;
  logic [N*CW-1:0] req_byte_cnt;
  logic [N-1:0]    req_ready;
  logic            valid_insert, ready_insert = 1'b0;
  logic [DW-1:0]   data_insert;
  logic [BW-1:0]   keep_insert;
  logic [CW-1:0]   byte_insert_cnt;
  logic            valid_out = 1'b0, ready_out = 1'b0, last_out = 1'b0;
  logic [IW-1:0]   grant_id;
  logic            busy;
`ifdef HDR_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  int checks = 0, errors = 0;

  axi_stream_header_arbiter #(.DATA_WD(DW), .NUM_REQ(N), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_keep(req_keep), .req_byte_cnt(req_byte_cnt), .req_ready(req_ready),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
    .grant_id(grant_id),
`ifdef HDR_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] hdr(int i);
    return (i == 0) ? 32'h00123456 : (32'hA5A50000 | DW'(i));
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic beats(logic v, logic r, logic l);
    valid_out = v; ready_out = r; last_out = l;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW]     = hdr(i);
      req_keep[i*BW +: BW]     = (i == 0) ? 4'h7 : 4'hF;
      req_byte_cnt[i*CW +: CW] = (i == 0) ? 2'd3 : CW'(i);
    end

    // Reset: request pending but nothing acknowledged.
    req_valid = 4'b0001;
    repeat (2) @(posedge clk);
    nxt(); #1;
    chk("rst_valid_insert", valid_insert, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_data", data_insert, 0);
    chk("rst_req_ready", req_ready, 0);

    // Single requester 0, immediate header accept.
    rst_n = 1'b1; ready_insert = 1'b1; #1;
    chk("t1_req_ready", req_ready, 4'b0001);
    nxt(); req_valid = '0; #1;
    chk("t1_valid_insert", valid_insert, 1);
    chk("t1_data", data_insert, 32'h00123456);
    chk("t1_keep", keep_insert, 4'b0111);
    chk("t1_cnt", byte_insert_cnt, 3);
    chk("t1_grant_id", grant_id, 0);
    chk("t1_no_ready_hdr", req_ready, 0);
    nxt(); beats(1, 1, 1); #1;
    chk("t1_pkt_valid", valid_insert, 0);
    chk("t1_pkt_busy", busy, 1);
    nxt(); beats(0, 0, 0); #1;
    chk("t1_idle", busy, 0);

    // All requesting: order 0,1,2,3,0 from a fresh pointer.
    rst_n = 1'b0;
    nxt(); rst_n = 1'b1; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      automatic int g = k % N;
      #1;
      chk("rr_req_ready", req_ready, N'(1) << g);
      chk("rr_bubble_idle", busy, 0);
      nxt(); #1;
      chk("rr_grant_id", grant_id, g);
      chk("rr_data", data_insert, hdr(g));
      nxt(); beats(1, 1, 1); #1;
      chk("rr_pkt", {busy, valid_insert}, 2'b10);
      nxt(); beats(0, 0, 0);
    end

    // Requester 2 with a 5-cycle inserter stall.
    req_valid = 4'b0100; ready_insert = 1'b0; #1;
    chk("t3_req_ready", req_ready, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      nxt(); req_valid = '0; #1;
      chk("t3_hold_valid", valid_insert, 1);
      chk("t3_hold_data", data_insert, hdr(2));
    end
    nxt(); ready_insert = 1'b1; #1;
    chk("t3_last_valid", valid_insert, 1);
    chk("t3_grant_id", grant_id, 2);

    // In PKT: last without ready_out does not end the packet.
    nxt(); req_valid = 4'b0010; beats(1, 0, 1); #1;
    chk("t4_pkt", {busy, valid_insert}, 2'b10);
    chk("t4_no_grant", req_ready, 0);
    nxt(); #1;
    chk("t4_still_pkt", busy, 1);
    chk("t4_still_no_grant", req_ready, 0);
    ready_out = 1'b1;
    nxt(); beats(0, 0, 0); ready_insert = 1'b0; #1;
    chk("t4_idle", busy, 0);
    chk("t4_req_ready_wrap", req_ready, 4'b0010);
    nxt(); beats(1, 1, 1); #1;
    chk("t4_hdr_grant", grant_id, 1);
    nxt(); beats(0, 0, 0); #1;
    chk("t4_hdr_ignores_beat", valid_insert, 1);

    // Reset during HDR.
    rst_n = 1'b0; #1;
    chk("t5_rst_no_ready", req_ready, 0);
    nxt(); #1;
    chk("t5_valid", valid_insert, 0);
    chk("t5_busy", busy, 0);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_data", data_insert, 0);
    rst_n = 1'b1; req_valid = 4'b1111; #1;
    chk("t5_ptr_zero", req_ready, 4'b0001);

`ifdef HDR_ARB_TIMEOUT_EN
    ready_insert = 1'b1;
    nxt(); #1;
    chk("tmo_hdr", valid_insert, 1);
    nxt();
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("tmo_wait_busy", busy, 1);
      chk("tmo_wait_err", timeout_err, 0);
      nxt();
    end
    #1;
    chk("tmo_err_pulse", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_next_req", req_ready, 4'b0010);
    nxt(); #1;
    chk("tmo_err_clear", timeout_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
